// File: rtl/param_pipe_shifter.sv
// Pipelined WIDTH-bit shifter (LSL/LSR/ASR/ROR/ROL) with valid/ready streaming and tag sideband.
// Optional flag outputs out_zero/out_carry are enabled by defining SHIFTER_FLAGS_EN.
module param_pipe_shifter #(
  parameter int WIDTH     = 8,
  parameter int SHAMT_W   = 8,
  parameter int STAGE_GRP = 1,
  parameter int TAG_W     = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
`ifdef SHIFTER_FLAGS_EN
  ,
  output logic               out_zero,
  output logic               out_carry
`endif
);

  localparam int NL = $clog2(WIDTH);
  localparam int NS = (NL + STAGE_GRP - 1) / STAGE_GRP;
  localparam int CW = (SHAMT_W > NL + 1) ? SHAMT_W : NL + 1;

  localparam logic [2:0] M_LSL = 3'b000;
  localparam logic [2:0] M_LSR = 3'b001;
  localparam logic [2:0] M_ASR = 3'b010;
  localparam logic [2:0] M_ROR = 3'b011;
  localparam logic [2:0] M_ROL = 3'b100;

  // One mux layer: shift by 2**l in the given mode; unknown modes pass through.
  function automatic logic [WIDTH-1:0] layer(input logic [WIDTH-1:0] d, input logic [2:0] m,
                                             input int l);
    int s;
    s = 1 << l;
    case (m)
      M_LSL:   return d << s;
      M_LSR:   return d >> s;
      M_ASR:   return $unsigned($signed(d) >>> s);
      M_ROR:   return (d >> s) | (d << (WIDTH - s));
      M_ROL:   return (d << s) | (d >> (WIDTH - s));
      default: return d;
    endcase
  endfunction

  logic              stall;
  logic [CW-1:0]     shamt_ext;
  logic              oor;
  logic [NL-1:0]     pre_amt;
  logic [WIDTH-1:0]  pre_data;

  // Stage 0 holds the decoded input; stages 1..NS each resolve one group of layers.
  logic [WIDTH-1:0]  data_q  [NS+1];
  logic [WIDTH-1:0]  data_d  [NS+1];
  logic [TAG_W-1:0]  tag_q   [NS+1];
  logic [TAG_W-1:0]  tag_d   [NS+1];
  logic              valid_q [NS+1];
  logic              valid_d [NS+1];
  logic [NL-1:0]     amt_q   [NS];
  logic [NL-1:0]     amt_d   [NS];
  logic [2:0]        mode_q  [NS];
  logic [2:0]        mode_d  [NS];

  assign stall     = valid_q[NS] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = valid_q[NS];
  assign out_data  = data_q[NS];
  assign out_tag   = tag_q[NS];

  // Out-of-range amounts are folded into the operand/amount up front so the layers never see them.
  always_comb begin
    shamt_ext = CW'(in_shamt);
    oor       = shamt_ext >= CW'(WIDTH);
    pre_amt   = shamt_ext[NL-1:0];
    pre_data  = in_data;
    if (oor) begin
      if (in_mode == M_LSL || in_mode == M_LSR) pre_data = '0;
      else if (in_mode == M_ASR)               pre_amt  = '1;
    end
  end

  always_comb begin
    logic [WIDTH-1:0] cur;
    data_d[0]  = pre_data;
    tag_d[0]   = in_tag;
    valid_d[0] = in_valid;
    amt_d[0]   = pre_amt;
    mode_d[0]  = in_mode;
    for (int s = 1; s <= NS; s++) begin
      cur = data_q[s-1];
      for (int l = 0; l < NL; l++) begin
        if ((l / STAGE_GRP) == (s - 1) && amt_q[s-1][l]) cur = layer(cur, mode_q[s-1], l);
      end
      data_d[s]  = cur;
      tag_d[s]   = tag_q[s-1];
      valid_d[s] = valid_q[s-1];
      if (s < NS) begin
        amt_d[s]  = amt_q[s-1];
        mode_d[s] = mode_q[s-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int s = 0; s <= NS; s++) begin
        data_q[s]  <= '0;
        tag_q[s]   <= '0;
        valid_q[s] <= 1'b0;
      end
      for (int s = 0; s < NS; s++) begin
        amt_q[s]  <= '0;
        mode_q[s] <= '0;
      end
    end else if (!stall) begin
      for (int s = 0; s <= NS; s++) begin
        data_q[s]  <= data_d[s];
        tag_q[s]   <= tag_d[s];
        valid_q[s] <= valid_d[s];
      end
      for (int s = 0; s < NS; s++) begin
        amt_q[s]  <= amt_d[s];
        mode_q[s] <= mode_d[s];
      end
    end
  end

`ifdef SHIFTER_FLAGS_EN
  logic          pre_carry;
  logic [NL-1:0] raw_amt;
  logic [NL-1:0] idx_dec;
  logic [NL-1:0] idx_neg;
  logic          carry_q [NS+1];
  logic          carry_d [NS+1];
  logic          zero_q;
  logic          zero_d;

  // The shifted-out bit only depends on the original operand, so it is picked at the input.
  always_comb begin
    raw_amt = shamt_ext[NL-1:0];
    idx_dec = raw_amt - NL'(1);
    idx_neg = NL'(0) - raw_amt;
    case (in_mode)
      M_LSL:   pre_carry = (shamt_ext != '0) && (shamt_ext <= CW'(WIDTH)) && in_data[idx_neg];
      M_LSR:   pre_carry = (shamt_ext != '0) && (shamt_ext <= CW'(WIDTH)) && in_data[idx_dec];
      M_ASR:   pre_carry = (shamt_ext != '0) && (oor ? in_data[WIDTH-1] : in_data[idx_dec]);
      M_ROR:   pre_carry = (raw_amt != '0) && in_data[idx_dec];
      M_ROL:   pre_carry = (raw_amt != '0) && in_data[idx_neg];
      default: pre_carry = 1'b0;
    endcase
  end

  always_comb begin
    carry_d[0] = pre_carry;
    for (int s = 1; s <= NS; s++) carry_d[s] = carry_q[s-1];
    zero_d = (data_d[NS] == '0);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int s = 0; s <= NS; s++) carry_q[s] <= 1'b0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      for (int s = 0; s <= NS; s++) carry_q[s] <= carry_d[s];
      zero_q <= zero_d;
    end
  end

  assign out_carry = carry_q[NS];
  assign out_zero  = zero_q;
`endif

endmodule

// File: doc/param_pipe_shifter.md
Name: param_pipe_shifter

Overview:
- Parametrised, pipelined successor to the 8-bit combinational ALU shift units.
- Performs logical left, logical right, arithmetic right, rotate right and rotate left on a WIDTH-bit operand.
- Built as log2(WIDTH) mux layers, with a pipeline register after every STAGE_GRP layers.
- Uses a valid/ready handshake so the multi-cycle ALU and the future wider datapath can stream shift operations with backpressure.

Parameters:
- WIDTH, 8: operand/result width; power of 2, minimum 4.
- SHAMT_W, 8: width of the shift-amount operand; the full value is interpreted unsigned.
- STAGE_GRP, 1: mux layers per pipeline stage; range 1..log2(WIDTH).
- TAG_W, 4: width of the sideband tag carried alongside each operation.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block accepts an input this cycle.
- in_data  in  WIDTH  operand to shift.
- in_shamt  in  SHAMT_W  shift amount.
- in_mode  in  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 ROL, others pass-through.
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shift result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset is synchronous and active-high on CLK (CLK/RESET naming as in the rest of the processor).
- While RESET=1 at an edge:
  - all stage valid bits clear;
  - out_valid=0, out_data=0, out_tag=0;
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation discards all in-flight operations; no result from them is ever presented.
- Latency: L = ceil(log2(WIDTH)/STAGE_GRP) cycles from accept (in_valid & in_ready at edge N) to out_valid at edge N+L, absent stalls.
  - WIDTH=8, STAGE_GRP=1 gives L=3.
- Throughput: one operation per cycle.
- Stall rule: stall = out_valid & ~out_ready; in_ready = ~stall.
  - During a stall every stage register (data, shamt, mode, tag, valid) holds.
  - out_data/out_tag stay stable while out_valid=1 and out_ready=0.
- Bubbles: empty stages shift forward when not stalled. A bubble reaching the output drops out_valid; out_data may hold its last value.
- Each stage resolves amount bits [k..k+STAGE_GRP-1] of the low log2(WIDTH) bits and carries the decoded out-of-range information.
- Out-of-range rule, applied when in_shamt >= WIDTH (full SHAMT_W compare):
  - LSL, LSR: result 0.
  - ASR: result = WIDTH copies of in_data[WIDTH-1].
  - ROR, ROL: amount taken modulo WIDTH, i.e. the low log2(WIDTH) bits only.
- Shift amount 0: result = in_data for every mode.
- Modes 101/110/111: result = in_data unchanged; tag and timing are normal.
- Simultaneous out handshake and new input in the same cycle: both occur with no bubble inserted.

Optional Feature:
- Macro: SHIFTER_FLAGS_EN.
- When defined, add two outputs pipelined in lockstep with out_data:
  - out_zero (1): result == 0.
  - out_carry (1): last bit shifted out.
- out_carry rules:
  - amount 0: 0.
  - LSL: in_data[WIDTH-amt] for 1 <= amt <= WIDTH, else 0.
  - LSR: in_data[amt-1] for 1 <= amt <= WIDTH, else 0.
  - ASR: in_data[amt-1] for amt < WIDTH, else in_data[WIDTH-1].
  - ROR: result[WIDTH-1]; ROL: result[0], for nonzero amount mod WIDTH, else 0.
  - Pass-through modes: 0.
- Both flags reset to 0.
- When the macro is not defined, the ports do not exist and no flag logic is synthesised.

Test Plan (WIDTH=8, STAGE_GRP=1, L=3 unless noted):
- LSL 0x81 by 1, tag 1 -> out_data=0x02, out_tag=1, out_valid exactly 3 cycles after accept; carry=1 when flags enabled.
- ASR 0x81 by 2 -> 0xE0; ASR 0x81 by 9 -> 0xFF; LSR 0x81 by 8 -> 0x00 with carry=1; LSL 0x81 by 200 -> 0x00.
- ROR 0x81 by 1 -> 0xC0; ROR 0x81 by 9 -> 0xC0; ROL 0x81 by 3 -> 0x0C; mode 111 with 0x5A by 3 -> 0x5A.
- Stream 5 back-to-back ops (tags 0..4), then hold out_ready=0 for 4 cycles once out_valid rises -> in_ready=0 during the stall, out_data held stable, all 5 results in tag order, none lost or duplicated.
- Assert RESET for 1 cycle with 3 ops in flight -> out_valid=0 next cycle; first post-reset op returns only its own result after 3 cycles.
- WIDTH=32, SHAMT_W=6, STAGE_GRP=2 (L=3): ASR 0x80000000 by 31 -> 0xFFFFFFFF; ROL 0x00000001 by 33 -> 0x00000002.
